// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter sharing one aesmodule core between N requesters.
// Define AES_ARB_TIMEOUT_EN to add the core-ready watchdog and the rsp_err output.
module aes_req_arbiter #(
   parameter int unsigned N       = 2,
   parameter int unsigned IDW     = 1,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N-1:0]      req_valid,
   output logic [N-1:0]      req_ready,
   input  logic [N*128-1:0]  req_data,
   input  logic [N-1:0]      req_decr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [127:0]      rsp_data,
   output logic [IDW-1:0]    rsp_id,
   output logic              rsp_decr,
`ifdef AES_ARB_TIMEOUT_EN
   output logic              rsp_err,
`endif
   output logic [127:0]      core_in,
   output logic              core_decr,
   output logic              core_reset,
   input  logic [127:0]      core_out,
   input  logic              core_ready,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StHold} state_e;

   state_e           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [127:0]     core_in_q, core_in_d;
   logic             core_decr_q, core_decr_d;
   logic [127:0]     rsp_data_q, rsp_data_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic             rsp_decr_q, rsp_decr_d;
   logic             first_q, first_d;

   logic [2*N-1:0]   req_dbl;
   logic [N-1:0]     req_rot;
   logic             gnt_found;
   logic [IDW-1:0]   gnt_off, gnt;
   logic [IDW:0]     gnt_sum, rr_next;
   logic [127:0]     sel_data;
   logic             sel_decr;

`ifdef AES_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             rsp_err_q, rsp_err_d;
   assign rsp_err = rsp_err_q;
`endif

   // Rotate requests so bit 0 is the rr_ptr requester, then take the lowest set bit.
   always_comb begin
      req_dbl   = {req_valid, req_valid};
      req_rot   = N'(req_dbl >> rr_ptr_q);
      gnt_found = 1'b0;
      gnt_off   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!gnt_found && req_rot[i]) begin
            gnt_found = 1'b1;
            gnt_off   = IDW'(i);
         end
      end
      gnt_sum = {1'b0, rr_ptr_q} + {1'b0, gnt_off};
      if (gnt_sum >= (IDW+1)'(N)) gnt_sum = gnt_sum - (IDW+1)'(N);
      gnt     = gnt_sum[IDW-1:0];
      rr_next = {1'b0, gnt} + (IDW+1)'(1);
      if (rr_next == (IDW+1)'(N)) rr_next = '0;
      sel_data = '0;
      sel_decr = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (IDW'(i) == gnt) begin
            sel_data = req_data[128*i +: 128];
            sel_decr = req_decr[i];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      id_d        = id_q;
      core_in_d   = core_in_q;
      core_decr_d = core_decr_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      rsp_decr_d  = rsp_decr_q;
      first_d     = first_q;
      req_ready   = '0;
`ifdef AES_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
      rsp_err_d   = rsp_err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (gnt_found) begin
               req_ready   = N'(1) << gnt;
               core_in_d   = sel_data;
               core_decr_d = sel_decr;
               id_d        = gnt;
               rr_ptr_d    = rr_next[IDW-1:0];
               state_d     = StLoad;
            end
         end
         StLoad: begin
            first_d = 1'b1;
`ifdef AES_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = StRun;
         end
         StRun: begin
            // A ready left over from the previous block may still be high in the first cycle.
            first_d = 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
            cnt_d   = cnt_q + CW'(1);
`endif
            if (!first_q && core_ready) begin
               rsp_data_d = core_out;
               rsp_decr_d = core_decr_q;
               rsp_id_d   = id_q;
`ifdef AES_ARB_TIMEOUT_EN
               rsp_err_d  = 1'b0;
`endif
               state_d    = StHold;
            end
`ifdef AES_ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
               rsp_data_d = '0;
               rsp_decr_d = core_decr_q;
               rsp_id_d   = id_q;
               rsp_err_d  = 1'b1;
               state_d    = StHold;
            end
`endif
         end
         StHold: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         core_in_q   <= '0;
         core_decr_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         rsp_decr_q  <= 1'b0;
         first_q     <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
         cnt_q       <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         core_in_q   <= core_in_d;
         core_decr_q <= core_decr_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         rsp_decr_q  <= rsp_decr_d;
         first_q     <= first_d;
`ifdef AES_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   assign core_in    = core_in_q;
   assign core_decr  = core_decr_q;
   assign core_reset = reset | (state_q == StLoad);
   assign rsp_valid  = (state_q == StHold);
   assign rsp_data   = rsp_data_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_decr   = rsp_decr_q;
   assign busy       = (state_q != StIdle);

endmodule
